// File: rtl/mem_bus_pkg.sv
// Shared definitions for the byte-wide memory bus initiator.
// Holds the request size encodings, the bus FSM state type, the bus
// byte width, the latched-request struct and a size->byte-count helper.
package mem_bus_pkg;

  localparam int BUS_BYTE_W = 8;
  localparam int WORD_BYTES = 4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR,
    ST_RESP
  } mem_bus_state_t;

  // Request fields captured on acceptance.
  typedef struct packed {
    logic        we;
    logic [2:0]  nbytes;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // 2'b11 is treated as a word access.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_lanes.sv
// Combinational byte-lane helper for mem_bus_master.
//   nbytes   in  3 : bytes in the access (1, 2 or 4)
//   sign_ext in  1 : fill upper lanes with the top loaded bit
//   raw      in 32 : assembled load bytes, byte k in lane k
//   wdata    in 32 : store data
//   idx      in  2 : current byte index
//   rdata    out 32: zero/sign-extended load result
//   wbyte    out 8 : store byte idx of wdata
module mem_byte_lanes
  import mem_bus_pkg::*;
(
  input  logic [2:0]  nbytes,
  input  logic        sign_ext,
  input  logic [31:0] raw,
  input  logic [31:0] wdata,
  input  logic [1:0]  idx,
  output logic [31:0] rdata,
  output logic [7:0]  wbyte
);

  logic fill;

  // Top bit of the highest loaded byte.
  always_comb begin
    case (nbytes)
      3'd1:    fill = raw[7];
      3'd2:    fill = raw[15];
      default: fill = raw[31];
    endcase
  end

  for (genvar j = 0; j < WORD_BYTES; j++) begin : g_lane
    assign rdata[BUS_BYTE_W*j +: BUS_BYTE_W] = (3'(j) < nbytes) ?
      raw[BUS_BYTE_W*j +: BUS_BYTE_W] : {BUS_BYTE_W{sign_ext & fill}};
  end

  assign wbyte = wdata[BUS_BYTE_W*idx +: BUS_BYTE_W];

endmodule

// File: rtl/mem_bus_master.sv
// Initiator side of the CPU byte-wide memory bus. Accepts 8/16/32-bit
// loads/stores on a valid/ready port, serialises them into single-byte
// little-endian read/write strobes and returns one response pulse per request.
// Optional feature macro: MEM_BUS_MASTER_TIMEOUT_EN (per-byte read timeout,
// TIMEOUT_CYCLES wait cycles, reported on resp_err).
// Ports:
//   clk, rst (sync, active high)
//   req_valid/req_ready/req_we/req_size/req_signed/req_addr/req_wdata : request
//   resp_valid/resp_rdata/resp_err                                     : response
//   mem_addr/mem_data_in/mem_data_out/memory_read_en/memory_write_en/mem_ready : bus
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_data_in,
  input  logic [7:0]  mem_data_out,
  output logic        memory_read_en,
  output logic        memory_write_en,
  input  logic        mem_ready
);

  mem_bus_state_t state_q, state_d;
  mem_req_t       req_q, req_d;
  logic [1:0]     idx_q, idx_d;
  logic [31:0]    lanes_q, lanes_d;
  logic           last_byte;
  logic           wait_expired;
  logic           timed_out;
  logic [31:0]    ext_word;
  logic [7:0]     wbyte;

  assign last_byte = (3'(idx_q) + 3'd1) == req_q.nbytes;

`ifdef MEM_BUS_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;

  // Counts RD_WAIT cycles of the current byte; restarts on every RD_REQ.
  always_ff @(posedge clk) begin
    if (rst || state_q == ST_RD_REQ) wait_cnt_q <= '0;
    else if (state_q == ST_RD_WAIT)  wait_cnt_q <= wait_cnt_q + 1'b1;
  end

  assign wait_expired = (state_q == ST_RD_WAIT) &&
                        (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wait_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    idx_d     = idx_q;
    lanes_d   = lanes_q;
    timed_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          req_d.we       = req_we;
          req_d.nbytes   = size_to_bytes(req_size);
          req_d.sign_ext = req_signed;
          req_d.addr     = req_addr;
          req_d.wdata    = req_wdata;
          idx_d          = 2'd0;
          lanes_d        = '0;
          state_d        = req_we ? ST_WR : ST_RD_REQ;
        end
      end
      ST_RD_REQ: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        // A late mem_ready on the expiring cycle still wins over the timeout.
        if (mem_ready) begin
          lanes_d[BUS_BYTE_W*idx_q +: BUS_BYTE_W] = mem_data_out;
          if (last_byte) state_d = ST_RESP;
          else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_RD_REQ;
          end
        end else if (wait_expired) begin
          timed_out = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_WR: begin
        if (last_byte) state_d = ST_RESP;
        else           idx_d   = idx_q + 2'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  mem_byte_lanes u_lanes (
    .nbytes   (req_d.nbytes),
    .sign_ext (req_d.sign_ext),
    .raw      (lanes_d),
    .wdata    (req_d.wdata),
    .idx      (idx_d),
    .rdata    (ext_word),
    .wbyte    (wbyte)
  );

  // Every output is registered from the next-state view so strobes line up
  // with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      req_q           <= '0;
      idx_q           <= '0;
      lanes_q         <= '0;
      req_ready       <= 1'b0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_err        <= 1'b0;
      mem_addr        <= '0;
      mem_data_in     <= '0;
      memory_read_en  <= 1'b0;
      memory_write_en <= 1'b0;
    end else begin
      state_q         <= state_d;
      req_q           <= req_d;
      idx_q           <= idx_d;
      lanes_q         <= lanes_d;
      req_ready       <= (state_d == ST_IDLE);
      memory_read_en  <= (state_d == ST_RD_REQ);
      memory_write_en <= (state_d == ST_WR);
      if (state_d == ST_RD_REQ || state_d == ST_WR)
        mem_addr <= req_d.addr + 32'(idx_d);
      if (state_d == ST_WR)
        mem_data_in <= wbyte;
      resp_valid <= (state_d == ST_RESP);
      resp_err   <= timed_out;
      resp_rdata <= (state_d == ST_RESP && !timed_out && !req_d.we) ? ext_word : '0;
    end
  end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Initiator side of the CPU's byte-wide memory bus. Accepts 8/16/32-bit load/store requests from the core on a valid/ready request port. Serialises each request into single-byte `memory_read_en`/`memory_write_en` transactions, little-endian, and returns one response pulse per request. Sits between the CPU datapath and the `memory` responder, and owns all bus sequencing so the core never drives bus strobes directly.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum cycles spent waiting for `mem_ready` on one byte. Only used with `MEM_BUS_MASTER_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: master idle, request accepted when both are high.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_signed` in 1: loads only; sign-extend from the top loaded byte.
- `req_addr` in 32: byte address of the lowest byte.
- `req_wdata` in 32: store data; byte k is `[8k+7:8k]`.
- `resp_valid` out 1: one-cycle completion pulse; no backpressure.
- `resp_rdata` out 32: load result; 0 for stores.
- `resp_err` out 1: timeout flag; constant 0 when the timeout feature is compiled out.
- `mem_addr` out 32: bus byte address.
- `mem_data_in` out 8: bus write data, driven toward memory.
- `mem_data_out` in 8: bus read data, driven from memory.
- `memory_read_en` out 1: read strobe.
- `memory_write_en` out 1: write strobe.
- `mem_ready` in 1: read data valid.

## Operation
- Byte count N: 1, 2 or 4 from `req_size`.
- Byte k goes to address `req_addr + k`, using a 32-bit add that wraps from 0xFFFFFFFF to 0.
- Misaligned requests are legal.
- Request fields are latched on acceptance.
- States:
  - IDLE: `req_ready` = 1. On accept, go to RD_REQ if the request is a load, WR if it is a store.
  - RD_REQ: `memory_read_en` = 1 for exactly one cycle. Go to RD_WAIT.
  - RD_WAIT: `memory_read_en` = 0. When `mem_ready` = 1, capture `mem_data_out` into lane k. Go to RD_REQ for the next byte, or to RESP after the last byte.
  - WR: `memory_write_en` = 1 with `mem_addr`/`mem_data_in` for byte k, one cycle per byte. Go to RESP after byte N-1.
  - RESP: `resp_valid` = 1 for one cycle. Return to IDLE.
- Load result: lanes at and above N are zero-filled. If `req_signed` is set, they are filled with bit `8N-1` instead.
- `memory_read_en` and `memory_write_en` are never high in the same cycle.
- All bus outputs are registered.
- `mem_addr` and `mem_data_in` hold their last value when no strobe is active.

## Timing
- Reset values:
  - `req_ready` = 0 while `rst` is high, 1 in the first cycle after release.
  - All other outputs are 0: `resp_valid`, `resp_rdata`, `resp_err`, `mem_addr`, `mem_data_in`, `memory_read_en`, `memory_write_en`.
- Cycle numbering: cycle 1 is the cycle after the accepting edge.
- Load latency with a one-cycle responder:
  - Byte k: RD_REQ in cycle 2k+1, RD_WAIT in cycle 2k+2.
  - `resp_valid` is high in cycle 2N+1 (word load: cycle 9).
- Store latency: bytes occupy cycles 1..N; `resp_valid` is high in cycle N+1 (word store: cycle 5).
- RD_WAIT extends by one cycle for each cycle `mem_ready` stays low.
- `mem_ready` outside RD_WAIT is ignored.
- `req_valid` while busy is held off (`req_ready` = 0) and never dropped.
- Back-to-back requests: the earliest next accept is the edge at the end of the cycle after RESP, since `req_ready` goes high only in IDLE.
- `rst` mid-request:
  - Abort at that edge; strobes are 0 from the next cycle.
  - No `resp_valid` is produced for the aborted request.
  - Bytes already written stay in memory.

## Configuration
- `MEM_BUS_MASTER_TIMEOUT_EN` defined:
  - An RD_WAIT cycle counter resets on each RD_REQ.
  - If `TIMEOUT_CYCLES` RD_WAIT cycles pass without `mem_ready`, abandon the remaining bytes and go to RESP with `resp_err` = 1 and `resp_rdata` = 0.
  - `resp_err` is 0 on normal completion.
- Not defined: no counter; RD_WAIT waits indefinitely; `resp_err` is tied to 0.

## Structure
- Shared package `mem_bus_pkg` holds:
  - Size encodings `SIZE_BYTE`/`SIZE_HALF`/`SIZE_WORD`.
  - FSM state enum `mem_bus_state_t`.
  - Bus byte width constant.
- Natural sub-module: `mem_byte_lanes`, combinational.
  - Inputs: N and the `req_signed` flag.
  - Performs lane placement and zero/sign extension of the assembled load word.
  - Selects store byte k from `req_wdata`.

## Test plan
- Word load at 0x10, memory bytes 0x11,0x22,0x33,0x44 -> `resp_rdata` 0x44332211; `resp_valid` in cycle 9; `memory_read_en` pulses on cycles 1,3,5,7.
- Word store 0xDEADBEEF at 0x20 -> addresses 0x20..0x23 written with 0xEF,0xBE,0xAD,0xDE in cycles 1-4; `resp_valid` in cycle 5; a readback load returns 0xDEADBEEF.
- Byte load of 0x80 with `req_signed` = 1 -> 0xFFFFFF80; with `req_signed` = 0 -> 0x00000080. Half load of 0x8001 signed -> 0xFFFF8001.
- Word load at 0xFFFFFFFE -> byte addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- `rst` asserted in cycle 3 of a word store -> only bytes 0-2 are written; no `resp_valid`; all outputs 0 in the next cycle; `req_ready` = 1 after release.
- With `MEM_BUS_MASTER_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, hold `mem_ready` = 0 -> `resp_err` = 1, `resp_rdata` = 0, back in IDLE; a following normal load completes with `resp_err` = 0.
